// File: rtl/sram_access_controller.sv
// Initiator-side controller for a single-port SRAM macro: valid/ready request channel,
// optional post-reset clear sweep, and an in-order read response FIFO.
module sram_access_controller #(
    parameter int unsigned      WIDTH         = 128,
    parameter int unsigned      NUM_ROWS      = 4096,
    parameter int unsigned      RSP_DEPTH     = 4,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    localparam int unsigned     AddressWidth  = $clog2(NUM_ROWS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    input  logic [WIDTH-1:0]        req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    init_done,
    output logic                    sram_ceb,
    output logic                    sram_web,
    output logic [AddressWidth-1:0] sram_a,
    output logic [WIDTH-1:0]        sram_d,
    output logic [WIDTH-1:0]        sram_m,
    input  logic [WIDTH-1:0]        sram_q
);

    localparam int unsigned PtrW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OccW  = CntW + 1;
    localparam int unsigned AddrW1 = AddressWidth + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [AddressWidth-1:0] init_cnt_q, init_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    rd_pending_q, rd_pending_d;
    logic [WIDTH-1:0]        buf_q [RSP_DEPTH];
    logic [WIDTH-1:0]        buf_d [RSP_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic                    push;
    logic                    pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Control FSM and SRAM pin drive; pins pass straight through in RUN since the macro registers them.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        req_ready  = 1'b0;
        sram_ceb   = 1'b0;
        sram_web   = 1'b0;
        sram_a     = req_addr;
        sram_d     = req_wdata;
        sram_m     = req_wmask;
        case (state_q)
            ST_INIT: begin
                sram_ceb   = !RST;
                sram_web   = !RST;
                sram_a     = init_cnt_q;
                sram_d     = INIT_VALUE;
                sram_m     = '1;
                init_cnt_d = init_cnt_q + AddressWidth'(1);
                if (init_cnt_q == AddressWidth'(NUM_ROWS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // In-flight read holds a buffer slot so its data always has room when it lands.
                req_ready = !RST && ((OccW'(count_q) + OccW'(rd_pending_q)) < OccW'(RSP_DEPTH));
                sram_ceb  = req_valid && req_ready;
                sram_web  = sram_ceb && req_write;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        init_done_d = (state_d == ST_RUN);
    end

    // Response FIFO: capture sram_q the cycle after a read issue, present the head registered.
    always_comb begin
        buf_d        = buf_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_pending_d = req_valid && req_ready && !req_write;
        push         = rd_pending_q;
        rsp_valid    = !RST && (count_q != '0);
        rsp_rdata    = rsp_valid ? buf_q[rd_ptr_q] : '0;
        pop          = rsp_valid && rsp_ready;
        if (push) begin
            buf_d[wr_ptr_q] = sram_q;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            rd_pending_q <= rd_pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Buffer payload needs no reset; validity is carried by count_q.
    always_ff @(posedge CLK) begin
        buf_q <= buf_d;
    end

    assign init_done = init_done_q;

    rsp_no_overflow_a: assert property (@(posedge CLK) disable iff (RST)
        !(push && !pop && (count_q == CntW'(RSP_DEPTH))));

    req_addr_in_range_a: assert property (@(posedge CLK) disable iff (RST)
        (req_valid && req_ready) |-> ({1'b0, req_addr} < AddrW1'(NUM_ROWS)));

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: SRAM macro model, queue-based reference model with a
// per-cycle compare process, and directed plus randomized stimulus.
module tb_sram_access_controller;

    localparam int unsigned W      = 8;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AW     = 4;
    localparam logic [W-1:0] INIT_V = 8'hA5;

    typedef struct {
        logic [W-1:0] d;
        int           cyc;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic [W-1:0]  req_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_rdata;
    logic          init_done;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [W-1:0]  sram_d;
    logic [W-1:0]  sram_m;
    logic [W-1:0]  sram_q = '0;

    logic [W-1:0]  sram_mem [ROWS];
    logic [W-1:0]  ref_mem  [ROWS];
    ent_t          exp_q[$];
    ent_t          rsp_log[$];
    int            outstanding = 0;
    int            since_rst = 0;
    int            gcyc = 0;
    int            last_rd_cyc = 0;
    bit            started = 1'b0;
    int            errors = 0;
    int            checks = 0;

    always #5 CLK = ~CLK;

    sram_access_controller #(
        .WIDTH(W), .NUM_ROWS(ROWS), .RSP_DEPTH(DEPTH), .INIT_ON_RESET(1'b1), .INIT_VALUE(INIT_V)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
        .sram_d(sram_d), .sram_m(sram_m), .sram_q(sram_q)
    );

    // Single-port SRAM macro: masked write, 1-cycle read, Q holds when not reading.
    always @(posedge CLK) begin
        if (sram_ceb) begin
            if (sram_web) sram_mem[sram_a] <= (sram_mem[sram_a] & ~sram_m) | (sram_d & sram_m);
            else          sram_q <= sram_mem[sram_a];
        end
    end

    initial begin
        for (int i = 0; i < ROWS; i++) begin
            sram_mem[i] = W'($urandom);
            ref_mem[i]  = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding-read count gates acceptance, queue of expected read data.
    always @(negedge CLK) begin
        bit   in_init;
        bit   exp_ready;
        bit   exp_ceb;
        bit   exp_valid;
        ent_t e;
        gcyc++;
        if (RST) begin
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
            chk("rst_sram_ceb",  32'(sram_ceb),  32'(0));
            chk("rst_sram_web",  32'(sram_web),  32'(0));
            exp_q.delete();
            outstanding = 0;
            since_rst   = 0;
            started     = 1'b1;
        end else if (started) begin
            in_init   = (since_rst < ROWS);
            exp_ready = !in_init && (outstanding < DEPTH);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("init_done", 32'(init_done), 32'(!in_init));
            if (in_init) begin
                chk("init_ceb", 32'(sram_ceb), 32'(1));
                chk("init_web", 32'(sram_web), 32'(1));
                chk("init_a",   32'(sram_a),   32'(since_rst));
                chk("init_d",   32'(sram_d),   32'(INIT_V));
                ref_mem[since_rst] = INIT_V;
            end else begin
                exp_ceb = req_valid && exp_ready;
                chk("sram_ceb", 32'(sram_ceb), 32'(exp_ceb));
                chk("sram_web", 32'(sram_web), 32'(exp_ceb && req_write));
                if (exp_ceb) begin
                    chk("sram_a", 32'(sram_a), 32'(req_addr));
                    chk("sram_d", 32'(sram_d), 32'(req_wdata));
                    chk("sram_m", 32'(sram_m), 32'(req_wmask));
                    if (req_write) begin
                        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                    end else begin
                        e.d = ref_mem[req_addr];
                        e.cyc = gcyc;
                        exp_q.push_back(e);
                        last_rd_cyc = gcyc;
                        outstanding++;
                    end
                end
            end
            exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= gcyc);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].d));
                if (rsp_ready) begin
                    e.d = rsp_rdata;
                    e.cyc = gcyc;
                    rsp_log.push_back(e);
                    void'(exp_q.pop_front());
                    outstanding--;
                end
            end
            since_rst++;
        end
    end

    task automatic apply_reset(input int n);
        RST = 1'b1;
        repeat (n) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic init_check();
        for (int k = 0; k < ROWS; k++) begin
            @(negedge CLK);
            chk("sweep_write", 32'(sram_ceb & sram_web), 32'(1));
            chk("sweep_addr", 32'(sram_a), 32'(k));
            chk("sweep_init_done_low", 32'(init_done), 32'(0));
        end
        @(negedge CLK);
        chk("init_done_rise", 32'(init_done), 32'(1));
        chk("post_init_idle", 32'(sram_ceb), 32'(0));
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input bit wr, input int addr, input logic [W-1:0] d, input logic [W-1:0] m);
        bit acc;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = AW'(addr);
        req_wdata = d;
        req_wmask = m;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            acc = req_ready;
            @(posedge CLK);
            #1;
            if (acc) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL issue_timeout: request addr %0d never accepted", addr);
    endtask

    task automatic wait_log(input int n, input string name);
        int t = 0;
        while (rsp_log.size() < n && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        chk({name, "_rsp_count"}, 32'(rsp_log.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int  accepted;
        bit  last_ready;

        apply_reset(3);
        init_check();

        // Freshly initialised row reads back the init value.
        rsp_log.delete();
        issue(1'b0, 7, '0, '0);
        wait_log(1, "init_read");
        if (rsp_log.size() > 0) chk("init_read_data", 32'(rsp_log[0].d), 32'h00A5);

        // Back-to-back write then read of the same row.
        rsp_log.delete();
        issue(1'b1, 3, 8'h3C, 8'hFF);
        issue(1'b0, 3, '0, '0);
        wait_log(1, "raw");
        if (rsp_log.size() > 0) begin
            chk("raw_data", 32'(rsp_log[0].d), 32'h003C);
            chk("raw_latency", 32'(rsp_log[0].cyc - last_rd_cyc), 32'(2));
        end

        // Masked partial overwrite.
        rsp_log.delete();
        issue(1'b1, 5, 8'hFF, 8'hFF);
        issue(1'b1, 5, 8'h00, 8'h0F);
        issue(1'b0, 5, '0, '0);
        wait_log(1, "mask");
        if (rsp_log.size() > 0) chk("mask_data", 32'(rsp_log[0].d), 32'h00F0);

        // Backpressure: only DEPTH reads fit while the consumer stalls.
        for (int i = 0; i < 6; i++) issue(1'b1, 8 + i, W'(8'h80 + i), 8'hFF);
        rsp_ready = 1'b0;
        rsp_log.delete();
        accepted = 0;
        last_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (accepted < 6);
            req_write = 1'b0;
            req_addr  = AW'(8 + accepted);
            @(negedge CLK);
            last_ready = req_ready;
            if (req_valid && req_ready) accepted++;
            @(posedge CLK);
            #1;
        end
        chk("bp_accepted", 32'(accepted), 32'(4));
        chk("bp_ready_low", 32'(last_ready), 32'(0));
        chk("bp_no_rsp", 32'(rsp_log.size()), 32'(0));
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && accepted < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = AW'(8 + accepted);
            @(negedge CLK);
            if (req_ready) accepted++;
            @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        chk("bp_total_accepted", 32'(accepted), 32'(6));
        wait_log(6, "bp");
        for (int i = 0; i < 6 && i < rsp_log.size(); i++) begin
            chk("bp_order", 32'(rsp_log[i].d), 32'(8'h80 + i));
        end

        // Streaming reads at full rate.
        for (int i = 0; i < 8; i++) issue(1'b1, i, W'(8'h10 + i), 8'hFF);
        rsp_log.delete();
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = AW'(i);
            @(negedge CLK);
            chk("stream_ready", 32'(req_ready), 32'(1));
            @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        wait_log(8, "stream");
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) begin
            chk("stream_data", 32'(rsp_log[i].d), 32'(8'h10 + i));
            if (i > 0) chk("stream_gap", 32'(rsp_log[i].cyc - rsp_log[i-1].cyc), 32'(1));
        end

        // Reset with reads in flight and buffered: nothing emerges, sweep restarts at row 0.
        rsp_ready = 1'b0;
        rsp_log.delete();
        issue(1'b0, 0, '0, '0);
        issue(1'b0, 1, '0, '0);
        issue(1'b0, 2, '0, '0);
        apply_reset(1);
        rsp_ready = 1'b1;
        init_check();
        repeat (4) @(posedge CLK);
        #1;
        chk("flush_no_rsp", 32'(rsp_log.size()), 32'(0));

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            RST       = (i == 700);
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = ($urandom_range(0, 2) == 0);
            req_addr  = AW'($urandom_range(0, ROWS - 1));
            req_wdata = W'($urandom);
            req_wmask = W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK);
            #1;
        end
        RST       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("drain_empty", 32'(outstanding), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
